// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and helpers shared by alu_seq.
// ALU_DIV_EN (optional) makes DIV/DIVU/REM/REMU iterative ops.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_AND   = 4'd0,
      ALU_OR    = 4'd1,
      ALU_ADD   = 4'd2,
      ALU_SUB   = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLT   = 4'd5,
      ALU_SLL   = 4'd6,
      ALU_SRL   = 4'd7,
      ALU_SRA   = 4'd8,
      ALU_MUL   = 4'd9,
      ALU_MULH  = 4'd10,
      ALU_MULHU = 4'd11,
      ALU_DIV   = 4'd12,
      ALU_DIVU  = 4'd13,
      ALU_REM   = 4'd14,
      ALU_REMU  = 4'd15
   } aluop_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Codes 12..15 are the divide family.
   function automatic logic is_div_op(input logic [3:0] op);
      return op[3] & op[2];
   endfunction

   function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_DIV_EN
      return op >= 4'd9;
`else
      return (op >= 4'd9) && !is_div_op(op);
`endif
   endfunction

endpackage

// File: rtl/alu_iter_core.sv
// alu_iter_core: one-bit-per-cycle shift-add multiplier / restoring divider.
// Ports: clk, rst_n, start, flush, mode (1=divide), a/b magnitudes,
// hi/lo (product hi/lo, or remainder/quotient), done (last step this cycle).
// The divide path exists only when ALU_DIV_EN is defined.
module alu_iter_core
   import alu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             flush,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             done
);

   logic             active;
   logic [SHW-1:0]   cnt;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] h, l, d;
   logic [WIDTH-1:0] h_nx, l_nx;
   logic [WIDTH:0]   sum;

   // The first step runs on the start edge straight from the operands,
   // so only WIDTH-1 further steps are needed in BUSY.
   assign h    = start ? '0 : hi;
   assign l    = start ? a  : lo;
   assign d    = start ? b  : opb;
   assign sum  = {1'b0, h} + {1'b0, d};
   assign done = active & (cnt == SHW'(WIDTH - 2));

`ifdef ALU_DIV_EN
   logic             mode_q;
   logic             m;
   logic [WIDTH:0]   rsh, diff;

   assign m    = start ? mode : mode_q;
   assign rsh  = {h, l[WIDTH-1]};
   assign diff = rsh - {1'b0, d};

   always_comb begin
      if (l[0]) {h_nx, l_nx} = {sum, l[WIDTH-1:1]};
      else      {h_nx, l_nx} = {1'b0, h, l[WIDTH-1:1]};
      if (m) begin
         if (!diff[WIDTH])
            {h_nx, l_nx} = {diff[WIDTH-1:0], l[WIDTH-2:0], 1'b1};
         else
            {h_nx, l_nx} = {rsh[WIDTH-1:0], l[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     mode_q <= 1'b0;
      else if (start) mode_q <= mode;
   end
`else
   logic unused_mode;
   assign unused_mode = mode;

   always_comb begin
      if (l[0]) {h_nx, l_nx} = {sum, l[WIDTH-1:1]};
      else      {h_nx, l_nx} = {1'b0, h, l[WIDTH-1:1]};
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= 1'b0;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         opb    <= '0;
      end else if (flush) begin
         active <= 1'b0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= '0;
         hi     <= h_nx;
         lo     <= l_nx;
         opb    <= b;
      end else if (active) begin
         cnt <= cnt + 1'b1;
         hi  <= h_nx;
         lo  <= l_nx;
         if (done) active <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with iterative mul/div behind valid/ready.
// Ports: clk, rst_n, in_valid/in_ready, aluctrl, src1, src2, flush,
// out_valid, result, zero, busy. ALU_DIV_EN enables the divide ops.
module alu_seq
   import alu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       aluctrl,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             flush,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy
);

   state_e             state;
   logic [3:0]         op_q;
   logic               neg_q, spec_q;
   logic [WIDTH-1:0]   spec_res_q;
   logic [WIDTH-1:0]   base, a_mag, b_mag, spec_res, fin, qr;
   logic [WIDTH-1:0]   hi, lo;
   logic [2*WIDTH-1:0] prod;
   logic [SHW-1:0]     shamt;
   logic               sgn, neg, special, mode, start, done;

   assign in_ready = (state == S_IDLE) & ~flush;
   assign busy     = (state != S_IDLE);
   assign shamt    = src2[SHW-1:0];
   assign start    = in_valid & in_ready & is_iter_op(aluctrl) & ~special;

   always_comb begin
      case (aluctrl)
         ALU_AND: base = src1 & src2;
         ALU_OR:  base = src1 | src2;
         ALU_ADD: base = src1 + src2;
         ALU_SUB: base = src1 - src2;
         ALU_XOR: base = src1 ^ src2;
         ALU_SLT: base = WIDTH'($signed(src1) < $signed(src2));
         ALU_SLL: base = src1 << shamt;
         ALU_SRL: base = src1 >> shamt;
         ALU_SRA: base = $signed(src1) >>> shamt;
         default: base = '0;
      endcase
   end

   // Signed ops iterate on magnitudes; neg records the final negation.
   always_comb begin
      sgn   = (aluctrl == ALU_MULH) | (aluctrl == ALU_DIV)
            | (aluctrl == ALU_REM);
      a_mag = (sgn & src1[WIDTH-1]) ? -src1 : src1;
      b_mag = (sgn & src2[WIDTH-1]) ? -src2 : src2;
      if (aluctrl == ALU_REM) neg = src1[WIDTH-1];
      else                    neg = sgn & (src1[WIDTH-1] ^ src2[WIDTH-1]);
   end

`ifdef ALU_DIV_EN
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

   // Divide-by-zero and MIN/-1 bypass the iterative core.
   always_comb begin
      mode     = is_div_op(aluctrl);
      special  = 1'b0;
      spec_res = '0;
      if (src2 == '0) begin
         special  = mode;
         spec_res = aluctrl[1] ? src1 : '1;
      end else if (src1 == MIN && &src2) begin
         special  = (aluctrl == ALU_DIV) | (aluctrl == ALU_REM);
         spec_res = aluctrl[1] ? '0 : src1;
      end
   end
`else
   assign mode     = 1'b0;
   assign special  = 1'b0;
   assign spec_res = '0;
`endif

   // hi holds the remainder and lo the quotient for divides.
   always_comb begin
      prod = neg_q ? -{hi, lo} : {hi, lo};
      qr   = op_q[1] ? hi : lo;
      if (neg_q) qr = -qr;
      fin = qr;
      if (op_q == ALU_MUL)
         fin = prod[WIDTH-1:0];
      else if (op_q == ALU_MULH || op_q == ALU_MULHU)
         fin = prod[2*WIDTH-1:WIDTH];
      if (spec_q) fin = spec_res_q;
   end

   alu_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .flush (flush),
      .mode  (mode),
      .a     (a_mag),
      .b     (b_mag),
      .hi    (hi),
      .lo    (lo),
      .done  (done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         out_valid  <= 1'b0;
         result     <= '0;
         zero       <= 1'b1;
         op_q       <= '0;
         neg_q      <= 1'b0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
      end else if (flush) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  if (is_iter_op(aluctrl)) begin
                     op_q       <= aluctrl;
                     neg_q      <= neg;
                     spec_q     <= special;
                     spec_res_q <= spec_res;
                     state      <= special ? S_DONE : S_BUSY;
                  end else begin
                     result    <= base;
                     zero      <= (base == '0);
                     out_valid <= 1'b1;
                  end
               end
            end
            S_BUSY: if (done) state <= S_DONE;
            S_DONE: begin
               result    <= fin;
               zero      <= (fin == '0);
               out_valid <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random requests against a queued reference
// model; a monitor pops expectations whenever out_valid is seen.
module tb_alu_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         flush = 1'b0;
   logic [3:0]   aluctrl = '0;
   logic [W-1:0] src1 = '0;
   logic [W-1:0] src2 = '0;
   logic         in_ready, out_valid, zero, busy;
   logic [W-1:0] result;

   int           cyc = 0;
   int           errors = 0;
   int           checks = 0;
   logic [W-1:0] last_res = '0;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] res;
      int           when;
   } exp_t;

   exp_t expq[$];
   exp_t me;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .aluctrl   (aluctrl),
      .src1      (src1),
      .src2      (src2),
      .flush     (flush),
      .out_valid (out_valid),
      .result    (result),
      .zero      (zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Reference: RV32M arithmetic done on 64-bit integers.
   function automatic void model(input logic [3:0] op,
                                 input logic [W-1:0] a, b,
                                 output logic [W-1:0] r,
                                 output int lat);
      int          sa, sb;
      longint      sp;
      logic [63:0] up;
      sa  = a;
      sb  = b;
      sp  = longint'(sa) * longint'(sb);
      up  = {32'b0, a} * {32'b0, b};
      lat = 1;
      case (op)
         4'd0: r = a & b;
         4'd1: r = a | b;
         4'd2: r = a + b;
         4'd3: r = a - b;
         4'd4: r = a ^ b;
         4'd5: r = (sa < sb) ? 1 : 0;
         4'd6: r = a << b[4:0];
         4'd7: r = a >> b[4:0];
         4'd8: r = sa >>> b[4:0];
         4'd9: begin r = up[31:0]; lat = 33; end
         4'd10: begin r = sp[63:32]; lat = 33; end
         4'd11: begin r = up[63:32]; lat = 33; end
         default: begin
`ifdef ALU_DIV_EN
            lat = 33;
            if (b == 0) begin
               lat = 2;
               r = (op == 12 || op == 13) ? '1 : a;
            end else if ((op == 12 || op == 14) && a == 32'h80000000
                         && b == 32'hFFFFFFFF) begin
               lat = 2;
               r = (op == 12) ? a : 0;
            end else if (op == 12) r = sa / sb;
            else if (op == 13)     r = a / b;
            else if (op == 14)     r = sa % sb;
            else                   r = a % b;
`else
            r = 0;
`endif
         end
      endcase
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return 32'h80000000;
         3: return 32'h7FFFFFFF;
         4: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, b,
                        input bit push);
      int           n;
      int           lat;
      logic [W-1:0] r;
      exp_t         e;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      aluctrl  = op;
      src1     = a;
      src2     = b;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL accept op%0d: got in_ready 0 expected 1", op);
      end else if (push) begin
         model(op, a, b, r, lat);
         e.op   = op;
         e.res  = r;
         e.when = cyc + lat;
         expq.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      src1     = $urandom;
      src2     = $urandom;
      aluctrl  = 4'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (expq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious out_valid: got %h expected none",
                        result);
            end else begin
               me = expq.pop_front();
               chk($sformatf("op%0d result", me.op), result, me.res);
               chk($sformatf("op%0d zero", me.op), zero, me.res == 0);
               chk($sformatf("op%0d latency", me.op), cyc, me.when);
               last_res = me.res;
            end
         end else if (expq.size() != 0 && expq[0].when < cyc) begin
            me = expq.pop_front();
            checks++;
            errors++;
            $display("FAIL op%0d out_valid: got none expected at cycle %0d",
                     me.op, me.when);
         end
      end
   end

   initial begin
      logic [3:0] op;
      logic [3:0] fl_op;
`ifdef ALU_DIV_EN
      fl_op = 4'd13;
`else
      fl_op = 4'd9;
`endif
      repeat (3) @(negedge clk);
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset busy", busy, 0);
      chk("reset result", result, 0);
      chk("reset zero", zero, 1);
      rst_n = 1'b1;

      issue(4'd2, 32'h7FFFFFFF, 32'h1, 1);
      issue(4'd3, 32'd5, 32'd5, 1);
      issue(4'd8, 32'h80000000, 32'd35, 1);
      issue(4'd6, 32'd1, 32'd32, 1);
      issue(4'd5, 32'hFFFFFFFF, 32'd1, 1);
      issue(4'd7, 32'h80000000, 32'd4, 1);
      issue(4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 1);

      issue(4'd9, 32'd7, 32'hFFFFFFFD, 1);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         chk("mul in_ready", in_ready, 0);
         chk("mul busy", busy, 1);
      end
      issue(4'd10, 32'h80000000, 32'h80000000, 1);
      issue(4'd11, 32'hFFFFFFFF, 32'd2, 1);
      issue(4'd12, 32'hFFFFFFF9, 32'd2, 1);
      issue(4'd14, 32'hFFFFFFF9, 32'd2, 1);
      issue(4'd13, 32'hFFFFFFFE, 32'd2, 1);
      issue(4'd12, 32'd9, 32'd0, 1);
      issue(4'd14, 32'd9, 32'd0, 1);
      issue(4'd12, 32'h80000000, 32'hFFFFFFFF, 1);
      issue(4'd14, 32'h80000000, 32'hFFFFFFFF, 1);
      drain();

      // Abort an iterative op part way through.
      issue(fl_op, 32'hFFFFFFF0, 32'd3, 0);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush in_ready", in_ready, 1);
      chk("flush busy", busy, 0);
      chk("flush out_valid", out_valid, 0);
      chk("flush result", result, last_res);
      repeat (40) @(negedge clk);

      // A request alongside flush must be refused.
      @(negedge clk);
      in_valid = 1'b1;
      aluctrl  = 4'd2;
      src1     = 32'd1;
      src2     = 32'd2;
      flush    = 1'b1;
      #1 chk("flush blocks in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      @(negedge clk);
      chk("flush request out_valid", out_valid, 0);
      chk("flush request result", result, last_res);

      // Asynchronous reset in the middle of an iterative op.
      issue(fl_op, 32'h12345678, 32'd9, 0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset in_ready", in_ready, 1);
      chk("midreset out_valid", out_valid, 0);
      chk("midreset busy", busy, 0);
      chk("midreset result", result, 0);
      chk("midreset zero", zero, 1);
      last_res = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      for (int i = 0; i < 150; i++) begin
         op = 4'($urandom);
         issue(op, pick(), pick(), 1);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      drain();
      repeat (2) @(negedge clk);
      chk("scoreboard empty", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
